// File: rtl/frame_source_ctrl.sv
// Frame source controller: routes a UART-assembled or camera pixel stream into
// a frame buffer, tracks frame progress and flags frame-integrity errors.
module frame_source_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int TOTAL_PIXELS = 9600,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_sel,
  input  logic                    uart_valid,
  input  logic [3*DATA_WIDTH-1:0] uart_rgb,
  input  logic                    uart_frame_done,
  input  logic                    cam_vsync,
  input  logic                    cam_valid,
  input  logic [3*DATA_WIDTH-1:0] cam_rgb,
  output logic                    fb_we,
  output logic [ADDR_WIDTH-1:0]   fb_addr,
  output logic [3*DATA_WIDTH-1:0] fb_wdata,
  output logic                    frame_ready,
  output logic                    busy,
  output logic                    active_src,
  output logic                    err_frame
);

  localparam int PIX_W = 3 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UART_RX  = 3'd1,
    CAM_WAIT = 3'd2,
    CAM_RX   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic                    fb_we_q, fb_we_d;
  logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]        fb_wdata_q, fb_wdata_d;
  logic                    frame_ready_q, frame_ready_d;
  logic                    busy_q, busy_d;
  logic                    active_src_q, active_src_d;
  logic                    err_frame_q, err_frame_d;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_wdata_d    = fb_wdata_q;
    frame_ready_d = 1'b0;
    active_src_d  = active_src_q;
    err_frame_d   = err_frame_q;

    case (state_q)
      IDLE: begin
        active_src_d = mode_sel;
        pix_cnt_d    = '0;
        state_d      = mode_sel ? CAM_WAIT : UART_RX;
      end

      UART_RX: begin
        if (uart_valid) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = pix_cnt_q;
          fb_wdata_d = uart_rgb;
          pix_cnt_d  = pix_cnt_q + ONE;
          if (pix_cnt_q == LAST_ADDR) begin
            state_d       = DONE;
            frame_ready_d = 1'b1;
          end
        end
        // A same-cycle pixel is counted before deciding if the frame was short.
        if (uart_frame_done) begin
          state_d       = DONE;
          frame_ready_d = 1'b1;
          if (!(uart_valid && pix_cnt_q == LAST_ADDR)) begin
            err_frame_d = 1'b1;
          end
        end
      end

      CAM_WAIT: begin
        if (cam_vsync) begin
          pix_cnt_d = '0;
          state_d   = CAM_RX;
        end
      end

      CAM_RX: begin
        if (cam_vsync) begin
          // Early vsync restarts the frame; a coincident pixel becomes pixel 0.
          err_frame_d = 1'b1;
          pix_cnt_d   = '0;
          if (cam_valid) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = '0;
            fb_wdata_d = cam_rgb;
            pix_cnt_d  = ONE;
            if (LAST_ADDR == '0) begin
              state_d       = DONE;
              frame_ready_d = 1'b1;
            end
          end
        end else if (cam_valid) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = pix_cnt_q;
          fb_wdata_d = cam_rgb;
          pix_cnt_d  = pix_cnt_q + ONE;
          if (pix_cnt_q == LAST_ADDR) begin
            state_d       = DONE;
            frame_ready_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= '0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      active_src_q  <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_wdata_q    <= fb_wdata_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      active_src_q  <= active_src_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wdata    = fb_wdata_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign active_src  = active_src_q;
  assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_frame_source_ctrl.sv
// Scoreboard bench for frame_source_ctrl with a 4-pixel frame: directed
// scenarios push expected writes, an independent monitor checks every write.
module tb_frame_source_ctrl;

  localparam int DW = 8;
  localparam int TP = 4;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode_sel = 1'b0;
  logic          uart_valid = 1'b0;
  logic [23:0]   uart_rgb = '0;
  logic          uart_frame_done = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_valid = 1'b0;
  logic [23:0]   cam_rgb = '0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_wdata;
  logic          frame_ready;
  logic          busy;
  logic          active_src;
  logic          err_frame;

  frame_source_ctrl #(.DATA_WIDTH(DW), .TOTAL_PIXELS(TP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel),
    .uart_valid(uart_valid), .uart_rgb(uart_rgb), .uart_frame_done(uart_frame_done),
    .cam_vsync(cam_vsync), .cam_valid(cam_valid), .cam_rgb(cam_rgb),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_ready(frame_ready), .busy(busy), .active_src(active_src), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  rdy_cnt = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every fb_we cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (frame_ready) rdy_cnt++;
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=0x%0h expected no write (t=%0t)",
                 fb_addr, fb_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(e.addr));
        chk("wr_data", 32'(fb_wdata), 32'(e.data));
        chk("wr_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic exp_wr(input logic [AW-1:0] a, input logic [23:0] d);
    exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
  endtask

  task automatic drive(input logic uv, input logic [23:0] urgb, input logic ufd,
                       input logic vs, input logic cv, input logic [23:0] crgb);
    uart_valid = uv; uart_rgb = urgb; uart_frame_done = ufd;
    cam_vsync = vs; cam_valid = cv; cam_rgb = crgb;
    @(negedge clk);
    uart_valid = 1'b0; uart_frame_done = 1'b0; cam_vsync = 1'b0; cam_valid = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_fb_we"}, 32'(fb_we), 0);
    chk({pfx, "_fb_addr"}, 32'(fb_addr), 0);
    chk({pfx, "_fb_wdata"}, 32'(fb_wdata), 0);
    chk({pfx, "_frame_ready"}, 32'(frame_ready), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_active_src"}, 32'(active_src), 0);
    chk({pfx, "_err_frame"}, 32'(err_frame), 0);
  endtask

  // Reset, then release so the first IDLE exit happens before the next negedge.
  task automatic do_reset(input logic mode, input bit check_zero);
    reset = 1'b1; mode_sel = mode;
    uart_valid = 1'b0; uart_frame_done = 1'b0; cam_vsync = 1'b0; cam_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (check_zero) chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_scn(input string pfx, input int r0, input int rdy_exp,
                            input logic err_exp, input logic src_exp);
    repeat (4) @(negedge clk);
    chk({pfx, "_frame_ready_pulses"}, rdy_cnt - r0, rdy_exp);
    chk({pfx, "_err_frame"}, 32'(err_frame), 32'(err_exp));
    chk({pfx, "_active_src"}, 32'(active_src), 32'(src_exp));
    chk({pfx, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;

    // Scenario 1: complete UART frame
    do_reset(1'b0, 1'b1);
    r0 = rdy_cnt;
    chk("s1_busy_entry", 32'(busy), 1);
    exp_wr(0, 24'h010203); drive(1, 24'h010203, 0, 0, 0, 0);
    exp_wr(1, 24'h040506); drive(1, 24'h040506, 0, 0, 0, 0);
    exp_wr(2, 24'h070809); drive(1, 24'h070809, 0, 0, 0, 0);
    exp_wr(3, 24'h0A0B0C); drive(1, 24'h0A0B0C, 0, 0, 0, 0);
    chk("s1_frame_ready_with_last_write", 32'(frame_ready), 1);
    finish_scn("s1", r0, 1, 1'b0, 1'b0);

    // Scenario 2: camera frame, pixel before vsync is dropped
    do_reset(1'b1, 1'b0);
    r0 = rdy_cnt;
    drive(0, 0, 0, 0, 1, 24'hFFFFFF);
    drive(0, 0, 0, 1, 0, 0);
    exp_wr(0, 24'h112233); drive(0, 0, 0, 0, 1, 24'h112233);
    exp_wr(1, 24'h445566); drive(0, 0, 0, 0, 1, 24'h445566);
    exp_wr(2, 24'h778899); drive(0, 0, 0, 0, 1, 24'h778899);
    exp_wr(3, 24'hAABBCC); drive(0, 0, 0, 0, 1, 24'hAABBCC);
    finish_scn("s2", r0, 1, 1'b0, 1'b1);

    // Scenario 3: short UART frame sets the sticky error
    do_reset(1'b0, 1'b0);
    r0 = rdy_cnt;
    exp_wr(0, 24'h123456); drive(1, 24'h123456, 0, 0, 0, 0);
    exp_wr(1, 24'h789ABC); drive(1, 24'h789ABC, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("s3_err_set", 32'(err_frame), 1);
    finish_scn("s3", r0, 1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("s3_err_sticky", 32'(err_frame), 1);

    // Scenario 4: early vsync with coincident pixel restarts at address 0
    do_reset(1'b1, 1'b0);
    r0 = rdy_cnt;
    chk("s4_err_cleared_by_reset", 32'(err_frame), 0);
    drive(0, 0, 0, 1, 0, 0);
    exp_wr(0, 24'h0000A1); drive(0, 0, 0, 0, 1, 24'h0000A1);
    exp_wr(1, 24'h0000A2); drive(0, 0, 0, 0, 1, 24'h0000A2);
    exp_wr(0, 24'h0000B0); drive(0, 0, 0, 1, 1, 24'h0000B0);
    chk("s4_err_on_early_vsync", 32'(err_frame), 1);
    exp_wr(1, 24'h0000B1); drive(0, 0, 0, 0, 1, 24'h0000B1);
    exp_wr(2, 24'h0000B2); drive(0, 0, 0, 0, 1, 24'h0000B2);
    exp_wr(3, 24'h0000B3); drive(0, 0, 0, 0, 1, 24'h0000B3);
    finish_scn("s4", r0, 1, 1'b1, 1'b1);

    // Scenario 5: mode_sel flip and camera strobes ignored during UART frame
    do_reset(1'b0, 1'b0);
    r0 = rdy_cnt;
    exp_wr(0, 24'hC0FFEE); drive(1, 24'hC0FFEE, 0, 0, 0, 0);
    mode_sel = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    exp_wr(1, 24'hBADA55); drive(1, 24'hBADA55, 0, 0, 1, 24'hDEAD01);
    drive(0, 0, 0, 0, 1, 24'hDEAD02);
    exp_wr(2, 24'h5EED00); drive(1, 24'h5EED00, 0, 0, 0, 0);
    chk("s5_active_src_mid", 32'(active_src), 0);
    exp_wr(3, 24'hF00D00); drive(1, 24'hF00D00, 0, 0, 1, 24'hDEAD03);
    chk("s5_active_src_at_done", 32'(active_src), 0);
    chk("s5_frame_ready_at_done", 32'(frame_ready), 1);
    mode_sel = 1'b0;
    finish_scn("s5", r0, 1, 1'b0, 1'b0);

    // Scenario 6: reset mid camera frame aborts it
    do_reset(1'b1, 1'b0);
    drive(0, 0, 0, 1, 0, 0);
    exp_wr(0, 24'h00C001); drive(0, 0, 0, 0, 1, 24'h00C001);
    exp_wr(1, 24'h00C002); drive(0, 0, 0, 0, 1, 24'h00C002);
    r0 = rdy_cnt;
    reset = 1'b1; cam_valid = 1'b1; cam_rgb = 24'h00C003;
    @(negedge clk);
    chk_zero("s6_after_reset");
    cam_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 24'h00C004);
    drive(0, 0, 0, 0, 1, 24'h00C005);
    finish_scn("s6", r0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
